// File: rtl/addsub_pkg.sv
// Shared definitions for the multi-cycle add/subtract unit: op encodings and FSM state type.
package addsub_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/addsub_limb.sv
// Combinational LIMB-bit adder with carry-in and carry-out; one limb of the serial datapath.
module addsub_limb #(
   parameter int LIMB = 16
) (
   input  logic [LIMB-1:0] a,
   input  logic [LIMB-1:0] b,
   input  logic            cin,
   output logic [LIMB-1:0] sum,
   output logic            cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{LIMB{1'b0}}, cin};

endmodule

// File: rtl/addsub_unit.sv
// Limb-serial two's-complement add/subtract, WIDTH/LIMB CALC cycles per operation.
// Optional saturation of z on signed overflow is enabled by defining ADDSUB_UNIT_SAT_EN.
module addsub_unit
   import addsub_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int LIMB  = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ack,
   output logic             busy,
   output logic             stb,
   output logic [WIDTH-1:0] z,
   output logic             cout,
   output logic             ovf,
   output state_t           fsm_state
);

   localparam int N  = WIDTH / LIMB;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (WIDTH % LIMB != 0) begin : g_bad_limb
      $error("addsub_unit: WIDTH must be a multiple of LIMB");
   end

   // Handshake: start is accepted only in IDLE; stb stays high in DONE until an edge with ack=1.
   state_t           state, state_next;
   logic [WIDTH-1:0] a_q, b_q, z_q, z_next;
   logic [CW-1:0]    k;
   logic             carry, op_q, cout_q, ovf_q;
   logic [LIMB-1:0]  limb_sum;
   logic             limb_cout;
   logic             last;
   logic             final_ovf;

   addsub_limb #(.LIMB(LIMB)) u_limb (
      .a    (a_q[k*LIMB +: LIMB]),
      .b    (b_q[k*LIMB +: LIMB]),
      .cin  (carry),
      .sum  (limb_sum),
      .cout (limb_cout)
   );

   assign last = (k == CW'(N - 1));

   always_comb begin
      z_next = z_q;
      z_next[k*LIMB +: LIMB] = limb_sum;
   end

   // b_q already holds the effective (possibly inverted) operand.
   assign final_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (z_next[WIDTH-1] != a_q[WIDTH-1]);

`ifdef ADDSUB_UNIT_SAT_EN
   logic [WIDTH-1:0] sat_val;
   assign sat_val = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = CALC;
         CALC:    if (last)  state_next = DONE;
         DONE:    if (ack)   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         a_q    <= '0;
         b_q    <= '0;
         z_q    <= '0;
         k      <= '0;
         carry  <= 1'b0;
         op_q   <= OP_ADD;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_q   <= a;
                  b_q   <= (op == OP_SUB) ? ~b : b;
                  carry <= op;
                  op_q  <= op;
                  k     <= '0;
               end
            end
            CALC: begin
               carry <= limb_cout;
               if (last) begin
                  k      <= '0;
                  cout_q <= (op_q == OP_SUB) ? ~limb_cout : limb_cout;
                  ovf_q  <= final_ovf;
`ifdef ADDSUB_UNIT_SAT_EN
                  z_q    <= final_ovf ? sat_val : z_next;
`else
                  z_q    <= z_next;
`endif
               end else begin
                  k   <= k + CW'(1);
                  z_q <= z_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign stb       = (state == DONE);
   assign z         = z_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign fsm_state = state;

endmodule

// File: tb/tb_addsub_unit.sv
// Directed bench for addsub_unit at WIDTH=64, LIMB=16 with hand-computed expected results.
module tb_addsub_unit;
   import addsub_pkg::*;

   logic        clock = 1'b0;
   logic        reset, start, op, ack;
   logic [63:0] a, b, z;
   logic        busy, stb, cout, ovf;
   state_t      fsm_state;

   int tests  = 0;
   int failed = 0;
   int lat;

   addsub_unit #(.WIDTH(64), .LIMB(16)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .ack       (ack),
      .busy      (busy),
      .stb       (stb),
      .z         (z),
      .cout      (cout),
      .ovf       (ovf),
      .fsm_state (fsm_state)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Issue one operation, scramble the inputs after the start edge, return stb latency in edges.
   task automatic launch(input logic [63:0] av, input logic [63:0] bv, input logic opv,
                         input logic hold_ack, output int latency);
      a = av; b = bv; op = opv; start = 1'b1;
      tick();
      start = 1'b0;
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 1'($urandom_range(0, 1));
      ack = hold_ack;
      latency = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (stb) begin
            latency = i;
            break;
         end
      end
      ack = 1'b0;
   endtask

   task automatic finish_op();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("stb_after_ack", {63'd0, stb}, 64'd0);
      check("busy_after_ack", {63'd0, busy}, 64'd0);
   endtask

   task automatic run(input string tag, input logic [63:0] av, input logic [63:0] bv,
                      input logic opv, input logic [63:0] ez, input logic ec, input logic eo);
      launch(av, bv, opv, 1'b0, lat);
      check({tag, "_lat"}, 64'(lat), 64'd4);
      check({tag, "_z"}, z, ez);
      check({tag, "_cout"}, {63'd0, cout}, {63'd0, ec});
      check({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
      finish_op();
   endtask

   initial begin
      logic [63:0] sat_hi, sat_lo;
`ifdef ADDSUB_UNIT_SAT_EN
      sat_hi = 64'h7FFF_FFFF_FFFF_FFFF;
      sat_lo = 64'h8000_0000_0000_0000;
`else
      sat_hi = 64'h8000_0000_0000_0000;
      sat_lo = 64'h7FFF_FFFF_FFFF_FFFF;
`endif
      reset = 1'b1; start = 1'b0; op = 1'b0; ack = 1'b0; a = '0; b = '0;
      tick(); tick();
      check("rst_stb", {63'd0, stb}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_z", z, 64'd0);
      check("rst_cout", {63'd0, cout}, 64'd0);
      check("rst_ovf", {63'd0, ovf}, 64'd0);
      check("rst_state", 64'(fsm_state), 64'(IDLE));

      // Release reset with start already asserted: first edge must accept it.
      reset = 1'b0;
      run("add5p3", 64'd5, 64'd3, OP_ADD, 64'd8, 1'b0, 1'b0);
      run("sub5m7", 64'd5, 64'd7, OP_SUB, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
      run("sub10m3", 64'd10, 64'd3, OP_SUB, 64'd7, 1'b0, 1'b0);
      run("limbcarry", 64'h0000_0000_0000_FFFF, 64'd1, OP_ADD, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
      run("addwrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD, 64'd0, 1'b1, 1'b0);
      run("posovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD, sat_hi, 1'b0, 1'b1);
      run("negovf", 64'h8000_0000_0000_0000, 64'd1, OP_SUB, sat_lo, 1'b0, 1'b1);

      // ack during CALC must not disturb the operation.
      launch(64'd100, 64'd23, OP_ADD, 1'b1, lat);
      check("ackcalc_lat", 64'(lat), 64'd4);
      check("ackcalc_z", z, 64'd123);
      finish_op();

      // Reset in the second CALC cycle.
      a = 64'd9; b = 64'd9; op = OP_ADD; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_stb", {63'd0, stb}, 64'd0);
      check("midrst_busy", {63'd0, busy}, 64'd0);
      check("midrst_z", z, 64'd0);
      run("after_rst", 64'd1, 64'd1, OP_ADD, 64'd2, 1'b0, 1'b0);

      // Hold DONE without ack; start pulses there and on the ack edge are ignored.
      launch(64'd40, 64'd2, OP_ADD, 1'b0, lat);
      check("hold_lat", 64'(lat), 64'd4);
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin a = 64'd1000; b = 64'd1; op = OP_SUB; start = 1'b1; end
         if (i == 5) start = 1'b0;
         tick();
         check("hold_z", z, 64'd42);
         check("hold_stb", {63'd0, stb}, 64'd1);
      end
      start = 1'b1; ack = 1'b1;
      tick();
      start = 1'b0; ack = 1'b0;
      check("ackstart_busy", {63'd0, busy}, 64'd0);
      check("ackstart_stb", {63'd0, stb}, 64'd0);
      tick();
      check("ackstart_idle", {63'd0, busy}, 64'd0);
      check("ackstart_z", z, 64'd42);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/addsub_unit.md
ADDSUB_UNIT -- requirements
Module: addsub_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning the operand and result width in bits.
REQ-002 The block SHALL have parameter LIMB, default 16, meaning the bits processed per CALC cycle; WIDTH SHALL be a multiple of LIMB, else elaboration error.
REQ-003 The block SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request; sampled only in IDLE.
REQ-006 The block SHALL have port op, input, 1 bit: 0 = add (a+b), 1 = subtract (a-b); sampled with start.
REQ-007 The block SHALL have ports a and b, inputs, WIDTH bits each: operands, two's complement; sampled with start.
REQ-008 The block SHALL have port ack, input, 1 bit: consumer has taken the result.
REQ-009 The block SHALL have port busy, output, 1 bit: high in CALC and DONE.
REQ-010 The block SHALL have port stb, output, 1 bit: result valid; high only in DONE.
REQ-011 The block SHALL have port z, output, WIDTH bits: result.
REQ-012 The block SHALL have port cout, output, 1 bit: carry-out for add, borrow for subtract.
REQ-013 The block SHALL have port ovf, output, 1 bit: signed overflow flag.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-015 In IDLE, a clock edge with start=1 SHALL latch a and op, latch b (inverted when op=1), set the carry-in to op, clear the limb counter, and enter CALC.
REQ-016 Each CALC edge SHALL add limb k of both operands plus the running carry, write limb k of z, and increment k; N = WIDTH/LIMB edges SHALL be spent in CALC.
REQ-017 On the Nth CALC edge the FSM SHALL enter DONE and assert stb, so stb is first high N edges after the edge that sampled start (4 for the defaults).
REQ-018 cout SHALL equal the final carry for add and the inverted final carry for subtract.
REQ-019 ovf SHALL be 1 iff the MSB of a equals the MSB of the effective b and differs from the MSB of z.
REQ-020 z, cout and ovf SHALL be held stable throughout DONE.
REQ-021 In DONE, an edge with ack=1 SHALL clear stb and return to IDLE; without ack the FSM SHALL stay in DONE indefinitely.
REQ-022 start SHALL be ignored in CALC and DONE, including on the same edge as ack; at least one IDLE cycle SHALL occur between operations.
REQ-023 ack outside DONE SHALL be ignored.
REQ-024 When LIMB = WIDTH, CALC SHALL last exactly one edge.
REQ-025 Changes on a, b or op after the start edge SHALL NOT affect the result.

Reset
REQ-026 Reset SHALL take priority over every other event, including mid-CALC and in DONE.
REQ-027 Reset SHALL force state IDLE, stb=0, busy=0, z=0, cout=0, ovf=0 and limb counter 0.
REQ-028 A start on the first edge after reset is released SHALL be accepted.

Configuration
REQ-029 With macro ADDSUB_UNIT_SAT_EN defined, z SHALL saturate when ovf=1: the maximum signed value if a is non-negative, the minimum signed value otherwise.
REQ-030 Without ADDSUB_UNIT_SAT_EN, z SHALL wrap modulo 2^WIDTH; ovf SHALL be reported identically in both builds.

Structure
REQ-031 Package addsub_pkg SHALL hold the op encodings OP_ADD=1'b0 and OP_SUB=1'b1 and the state typedef.
REQ-032 One combinational sub-module, addsub_limb, SHALL implement a LIMB-bit adder with carry-in and carry-out; it SHALL be instantiated once and reused each cycle.

Verification (WIDTH=64, LIMB=16)
REQ-033 Add 5+3 SHALL give z=8, cout=0, ovf=0, with stb high 4 edges after the start edge.
REQ-034 Subtract 5-7 SHALL give z=0xFFFF_FFFF_FFFF_FFFE, cout=1, ovf=0.
REQ-035 Add 0x0000_0000_0000_FFFF+1 SHALL give z=0x0000_0000_0001_0000, proving carry crosses limbs.
REQ-036 Add 0x7FFF_FFFF_FFFF_FFFF+1 SHALL give ovf=1, with z=0x8000_0000_0000_0000 (wrap build) or z=0x7FFF_FFFF_FFFF_FFFF (ADDSUB_UNIT_SAT_EN build).
REQ-037 Reset on the 2nd CALC cycle SHALL give stb=0, busy=0, z=0 on the next cycle, and a subsequent add 1+1 SHALL give z=2.
REQ-038 With ack held off 10 cycles, z SHALL stay stable; start pulsed in DONE and on the ack edge SHALL be ignored, and busy SHALL fall after ack.
